display_scan_controller: RTL and testbench

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

---
 rtl/display_scan_controller.sv | 136 +++++++++++++
 tb/tb_display_scan_controller.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// display_scan_controller
// Time-multiplexes a 4-digit hex value onto a shared 4-bit-to-7-segment
// decoder. Each digit owns a slot of CLOCK_DIVIDER cycles; the first
// BLANK_CYCLES of every slot are dark. This hides ghosting and covers the
// one-cycle decoder latency. A new value is taken through a
// valid/ready handshake into a one-deep pending buffer. It is committed to
// the displayed value only at the frame wrap, so a frame is never torn.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to keep leading-zero digits
// dark. Digit 0 is always shown.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   value_in     four hex digits, [3:0] is digit 0 (rightmost)
//   value_valid  producer offers value_in
//   value_ready  controller can accept a value (pending buffer empty)
//   digit_nibble nibble for the shared decoder (registered)
//   digit_enable one-hot digit enable, aligned with the decoder output
//   frame_done   one-cycle pulse after each completed 4-digit frame
module display_scan_controller #(
    parameter int unsigned CLOCK_DIVIDER = 50000,
    parameter int unsigned BLANK_CYCLES  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic        value_valid,
    output logic        value_ready,
    output logic [3:0]  digit_nibble,
    output logic [3:0]  digit_enable,
    output logic        frame_done
);

    localparam int unsigned CW = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(CLOCK_DIVIDER - 1);

    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

    state_t        state;
    logic [CW-1:0] counter;
    logic [1:0]    index;
    logic [15:0]   active;
    logic [15:0]   pending;
    logic          pending_full;

    logic       slot_end;
    logic       wrap;
    logic       accept;
    logic [1:0] next_index;

    // Select one nibble of a 16-bit value
    function automatic logic [3:0] nibble_sel(input logic [15:0] v, input logic [1:0] i);
        logic [3:0] n;
        case (i)
            2'd0:    n = v[3:0];
            2'd1:    n = v[7:4];
            2'd2:    n = v[11:8];
            default: n = v[15:12];
        endcase
        return n;
    endfunction

    assign slot_end   = (state == SHOW) && (counter == SLOT_LAST);
    assign wrap       = slot_end && (index == 2'd3);
    assign accept     = value_valid && !pending_full;
    assign next_index = index + 2'd1;
    assign value_ready = !pending_full;

    // Slot sequencer, display value commit and handshake
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= BLANK;
            counter      <= '0;
            index        <= 2'd0;
            active       <= 16'h0000;
            pending      <= 16'h0000;
            pending_full <= 1'b0;
            digit_nibble <= 4'h0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= wrap;

            case (state)
                BLANK: begin
                    counter <= counter + CW'(1);
                    if (counter == BLANK_LAST) begin
                        state <= SHOW;
                    end
                end
                SHOW: begin
                    if (counter == SLOT_LAST) begin
                        counter <= '0;
                        state   <= BLANK;
                        index   <= next_index;
                        // Nibble is preloaded at slot start so it is stable before the digit lights
                        if (wrap && pending_full) begin
                            active       <= pending;
                            digit_nibble <= pending[3:0];
                        end else begin
                            digit_nibble <= nibble_sel(active, next_index);
                        end
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                default: begin
                    state   <= BLANK;
                    counter <= '0;
                end
            endcase

            // A commit and an accept never coincide: ready is low whenever a commit is possible
            if (wrap && pending_full) begin
                pending_full <= 1'b0;
            end else if (accept) begin
                pending      <= value_in;
                pending_full <= 1'b1;
            end
        end
    end

    // Digit enable decoded from registers only
    always_comb begin
        digit_enable = 4'b0000;
        if (state == SHOW) begin
            digit_enable = 4'b0001 << index;
        end
`ifdef LEADING_ZERO_BLANK_EN
        digit_enable = digit_enable & {|active[15:12], |active[15:8], |active[15:4], 1'b1};
`else
`endif
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller (CLOCK_DIVIDER=8, BLANK_CYCLES=2).
// The reference model works from elapsed cycles since reset release. It keeps the
// displayed and pending values as transactions.
module tb_display_scan_controller;

    localparam int CD = 8;
    localparam int BC = 2;
    localparam int FRAME = 4 * CD;

    logic        clock;
    logic        reset;
    logic [15:0] value_in;
    logic        value_valid;
    logic        value_ready;
    logic [3:0]  digit_nibble;
    logic [3:0]  digit_enable;
    logic        frame_done;

    int          vectors;
    int          miscompares;
    int          t;
    logic [15:0] m_active;
    logic [15:0] m_pending;
    logic        m_full;
    logic [10:0] got;
    logic [10:0] want;

    display_scan_controller #(
        .CLOCK_DIVIDER(CD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .value_in    (value_in),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .digit_nibble(digit_nibble),
        .digit_enable(digit_enable),
        .frame_done  (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected {value_ready, frame_done, digit_enable, digit_nibble} for cycle tt
    function automatic logic [10:0] model_out(input int tt, input logic [15:0] act, input logic full);
        int         idx;
        int         ph;
        logic [3:0] en;
        logic [3:0] nib;
        idx = (tt / CD) % 4;
        ph  = tt % CD;
        en  = (ph < BC) ? 4'b0000 : 4'(1 << idx);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 1 && act[15:4] == 12'h000) en = 4'b0000;
        if (idx == 2 && act[15:8] == 8'h00) en = 4'b0000;
        if (idx == 3 && act[15:12] == 4'h0) en = 4'b0000;
`endif
        nib = 4'((act >> (4 * idx)) & 16'h000F);
        return {!full, (tt != 0) && (tt % FRAME == 0), en, nib};
    endfunction

    // Advance one clock and update the transaction model
    task automatic tick();
        logic        acc;
        logic [15:0] v;
        acc = value_valid && !m_full;
        v   = value_in;
        @(posedge clock);
        #1;
        if ((t % FRAME) == FRAME - 1 && m_full) begin
            m_active = m_pending;
            m_full   = 1'b0;
        end
        if (acc) begin
            m_pending = v;
            m_full    = 1'b1;
        end
        t++;
    endtask

    task automatic test_reset();
        reset = 1'b1; value_valid = 1'b0; value_in = 16'h0;
        t = 0; m_active = 16'h0; m_pending = 16'h0; m_full = 1'b0;
        #1;
        vectors++;
        got = {value_ready, frame_done, digit_enable, digit_nibble};
        if (got !== 11'b1_0_0000_0000) begin
            miscompares++;
            $display("FAIL reset_hold got=%b want=%b", got, 11'b1_0_0000_0000);
        end
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            vectors++;
            got = {value_ready, frame_done, digit_enable, digit_nibble};
            want = model_out(t, m_active, m_full);
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset_release t=%0d got=%b want=%b", t, got, want);
            end
        end
    endtask

    task automatic test_timing();
        int pulses;
        pulses = 0;
        value_valid = 1'b0;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            tick();
            if (frame_done) pulses++;
            vectors++;
            got = {value_ready, frame_done, digit_enable, digit_nibble};
            want = model_out(t, m_active, m_full);
            if (got !== want) begin
                miscompares++;
                $display("FAIL timing t=%0d got=%b want=%b", t, got, want);
            end
        end
        vectors++;
        if (pulses !== 2) begin
            miscompares++;
            $display("FAIL frame_pulses got=%0d want=2", pulses);
        end
    endtask

    task automatic test_load();
        int n;
        n = 0;
        value_valid = 1'b0;
        while (m_full && n < 100) begin tick(); n++; end
        value_in = 16'h1234; value_valid = 1'b1;
        tick();
        value_valid = 1'b0; value_in = 16'h0;
        vectors++;
        if (value_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL load_ready_low got=%b want=0", value_ready);
        end
        n = 0;
        while (!(m_active == 16'h1234 && (t % FRAME) == BC) && n < 100) begin
            tick(); n++;
            vectors++;
            got = {value_ready, frame_done, digit_enable, digit_nibble};
            want = model_out(t, m_active, m_full);
            if (got !== want) begin
                miscompares++;
                $display("FAIL load t=%0d got=%b want=%b", t, got, want);
            end
        end
        vectors++;
        if (n >= 100) begin
            miscompares++;
            $display("FAIL load_timeout got=%0d cycles want<100", n);
        end
        for (int d = 0; d < 4; d++) begin
            if (d > 0) for (int k = 0; k < CD; k++) tick();
            vectors++;
            got = {value_ready, frame_done, digit_enable, digit_nibble};
            want = {1'b1, 1'b0, 4'(1 << d), 4'(4 - d)};
            if (got !== want) begin
                miscompares++;
                $display("FAIL load_digit%0d got=%b want=%b", d, got, want);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        n = 0;
        value_valid = 1'b0;
        while (m_full && n < 100) begin tick(); n++; end
        value_in = 16'hAAAA; value_valid = 1'b1;
        tick();
        value_in = 16'h5555;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            vectors++;
            got = {value_ready, frame_done, digit_enable, digit_nibble};
            want = model_out(t, m_active, m_full);
            if (got !== want) begin
                miscompares++;
                $display("FAIL backpressure t=%0d got=%b want=%b", t, got, want);
            end
        end
        value_valid = 1'b0;
        vectors++;
        if (m_active !== 16'h5555 || digit_nibble !== 4'h5) begin
            miscompares++;
            $display("FAIL backpressure_final got=%h want=5", digit_nibble);
        end
    endtask

    task automatic test_wrap_edge();
        int n;
        n = 0;
        value_valid = 1'b0;
        while (!((t % FRAME) == FRAME - 1 && !m_full) && n < 100) begin tick(); n++; end
        value_in = 16'hBEEF; value_valid = 1'b1;
        tick();
        value_valid = 1'b0; value_in = 16'h0;
        for (int i = 0; i < FRAME + BC; i++) begin
            tick();
            vectors++;
            got = {value_ready, frame_done, digit_enable, digit_nibble};
            want = model_out(t, m_active, m_full);
            if (got !== want) begin
                miscompares++;
                $display("FAIL wrap_edge t=%0d got=%b want=%b", t, got, want);
            end
        end
        vectors++;
        if (digit_nibble !== 4'hF || digit_enable !== 4'b0001 || value_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_edge_beef got=%h/%b want=f/0001", digit_nibble, digit_enable);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            value_valid = ($urandom % 4) == 0;
            value_in    = 16'($urandom);
            tick();
            vectors++;
            got = {value_ready, frame_done, digit_enable, digit_nibble};
            want = model_out(t, m_active, m_full);
            if (got !== want) begin
                miscompares++;
                $display("FAIL random t=%0d got=%b want=%b", t, got, want);
            end
        end
        value_valid = 1'b0;
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    task automatic test_leading_zero();
        logic [15:0] vals [2];
        vals[0] = 16'h0050;
        vals[1] = 16'h0000;
        for (int v = 0; v < 2; v++) begin
            int n;
            n = 0;
            value_valid = 1'b0;
            while (m_full && n < 100) begin tick(); n++; end
            value_in = vals[v]; value_valid = 1'b1;
            tick();
            value_valid = 1'b0;
            for (int i = 0; i < 3 * FRAME; i++) begin
                tick();
                vectors++;
                got = {value_ready, frame_done, digit_enable, digit_nibble};
                want = model_out(t, m_active, m_full);
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL leading_zero t=%0d got=%b want=%b", t, got, want);
                end
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        int n;
        n = 0;
        value_valid = 1'b0;
        while (m_full && n < 100) begin tick(); n++; end
        value_in = 16'hC0DE; value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        n = 0;
        while (!(((t / CD) % 4) == 2 && (t % CD) == 4) && n < 100) begin tick(); n++; end
        #1 reset = 1'b1;
        #1;
        vectors++;
        got = {value_ready, frame_done, digit_enable, digit_nibble};
        if (got !== 11'b1_0_0000_0000 || !m_full) begin
            miscompares++;
            $display("FAIL reset_mid got=%b want=%b", got, 11'b1_0_0000_0000);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        t = 0; m_active = 16'h0; m_pending = 16'h0; m_full = 1'b0;
        for (int i = 0; i < FRAME + CD; i++) begin
            if (i > 0) tick();
            vectors++;
            got = {value_ready, frame_done, digit_enable, digit_nibble};
            want = model_out(t, m_active, m_full);
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset_mid_after t=%0d got=%b want=%b", t, got, want);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_timing();
        test_load();
        test_backpressure();
        test_wrap_edge();
        test_random();
`ifdef LEADING_ZERO_BLANK_EN
        test_leading_zero();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
